// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler
//   Paces readout of the 8-channel ADC interface. A divider produces periodic
//   sample ticks, which start only after a post-reset warmup. On each tick all
//   eight channel words are added into per-channel accumulators. After
//   2^AVG_LOG2 ticks the block average is latched. The averages for the
//   channels enabled in CH_MASK are then streamed out over a valid/ready
//   handshake.
//
// Ports
//   CLOCK, RESET          system clock, asynchronous active-low reset
//   ENABLE                scan enable (gates divider, clears accumulation)
//   CH_MASK[7:0]          per-channel stream enable, captured per result set
//   CH0..CH7[11:0]        latest conversion words
//   OUT_VALID/OUT_READY   result beat handshake
//   OUT_CH[2:0]           channel index of the beat
//   OUT_DATA[11:0]        averaged value
//   OUT_LAST              last enabled channel of the set
//   BUSY                  streaming in progress
//   OVERRUN               sticky: a completed set was dropped while streaming
//   CLR_OVERRUN           clears OVERRUN (a simultaneous new overrun wins)
//
// State table
//   ST_ACCUM  | waiting for a result set; accumulation runs
//   ST_STREAM | presenting beats of the captured set; accumulation still runs
module adc_scan_scheduler #(
  parameter int SAMPLE_DIV = 50000,
  parameter int AVG_LOG2   = 2,
  parameter int WARMUP     = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [7:0]  CH_MASK,
  input  logic [11:0] CH0,
  input  logic [11:0] CH1,
  input  logic [11:0] CH2,
  input  logic [11:0] CH3,
  input  logic [11:0] CH4,
  input  logic [11:0] CH5,
  input  logic [11:0] CH6,
  input  logic [11:0] CH7,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [2:0]  OUT_CH,
  output logic [11:0] OUT_DATA,
  output logic        OUT_LAST,
  output logic        BUSY,
  output logic        OVERRUN,
  input  logic        CLR_OVERRUN
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int ACC_W  = 12 + AVG_LOG2;
  localparam int SNAP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SNAP_W-1:0] SNAP_LAST = SNAP_W'((1 << AVG_LOG2) - 1);

  typedef enum logic {ST_ACCUM, ST_STREAM} state_t;

  state_t             state_q, state_d;
  logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SNAP_W-1:0]  snap_q, snap_d;
  logic [ACC_W-1:0]   acc_q [8];
  logic [ACC_W-1:0]   acc_d [8];
  logic [11:0]        res_q [8];
  logic [11:0]        res_d [8];
  logic [7:0]         mask_q, mask_d;
  logic [2:0]         ptr_q, ptr_d;
  logic               overrun_q, overrun_d;

  logic [11:0]        ch [8];
  logic [ACC_W-1:0]   sum [8];
  logic [11:0]        res_new [8];
  logic               warm_done, run, tick, set_done;
  logic [2:0]         first_ptr, next_ptr;
  logic               has_next;

  assign ch[0] = CH0;
  assign ch[1] = CH1;
  assign ch[2] = CH2;
  assign ch[3] = CH3;
  assign ch[4] = CH4;
  assign ch[5] = CH5;
  assign ch[6] = CH6;
  assign ch[7] = CH7;

  // Warmup is a down-counter that reloads on reset and stops at zero.
  assign warm_done = (warm_cnt_q == '0);
  assign run       = warm_done && ENABLE;
  assign tick      = run && (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_comb begin
    warm_cnt_d = warm_cnt_q;
    if (!warm_done) warm_cnt_d = warm_cnt_q - 1'b1;

    div_d = div_q;
    if (!run || tick) div_d = '0;
    else              div_d = div_q + 1'b1;

    snap_d   = snap_q;
    set_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      acc_d[i]   = acc_q[i];
      sum[i]     = acc_q[i] + ACC_W'(ch[i]);
      res_new[i] = 12'(sum[i] >> AVG_LOG2);
    end

    // The completing tick folds in the current sample directly, so the
    // accumulators only ever hold 2^AVG_LOG2-1 samples and cannot overflow.
    if (!ENABLE) begin
      snap_d = '0;
      for (int i = 0; i < 8; i++) acc_d[i] = '0;
    end else if (tick) begin
      if (snap_q == SNAP_LAST) begin
        snap_d   = '0;
        set_done = 1'b1;
        for (int i = 0; i < 8; i++) acc_d[i] = '0;
      end else begin
        snap_d = snap_q + 1'b1;
        for (int i = 0; i < 8; i++) acc_d[i] = sum[i];
      end
    end
  end

  // Lowest set bit of the incoming mask, and next set bit above ptr in the
  // captured mask (descending scan so the lowest match is the one kept).
  always_comb begin
    first_ptr = '0;
    for (int j = 7; j >= 0; j--) begin
      if (CH_MASK[j]) first_ptr = 3'(j);
    end
    next_ptr = ptr_q;
    has_next = 1'b0;
    for (int j = 7; j >= 0; j--) begin
      if (mask_q[j] && (3'(j) > ptr_q)) begin
        next_ptr = 3'(j);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    overrun_d = overrun_q;
    for (int i = 0; i < 8; i++) res_d[i] = res_q[i];

    if (CLR_OVERRUN) overrun_d = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        if (set_done && (CH_MASK != '0)) begin
          state_d = ST_STREAM;
          mask_d  = CH_MASK;
          ptr_d   = first_ptr;
          for (int i = 0; i < 8; i++) res_d[i] = res_new[i];
        end
      end
      ST_STREAM: begin
        if (set_done) overrun_d = 1'b1;
        if (OUT_READY) begin
          if (has_next) ptr_d = next_ptr;
          else          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_ACCUM;
      warm_cnt_q <= WARM_W'(WARMUP);
      div_q      <= '0;
      snap_q     <= '0;
      mask_q     <= '0;
      ptr_q      <= '0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        acc_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      div_q      <= div_d;
      snap_q     <= snap_d;
      mask_q     <= mask_d;
      ptr_q      <= ptr_d;
      overrun_q  <= overrun_d;
      for (int i = 0; i < 8; i++) begin
        acc_q[i] <= acc_d[i];
        res_q[i] <= res_d[i];
      end
    end
  end

  assign BUSY      = (state_q == ST_STREAM);
  assign OUT_VALID = BUSY;
  assign OUT_CH    = ptr_q;
  assign OUT_DATA  = res_q[ptr_q];
  assign OUT_LAST  = BUSY && !has_next;
  assign OVERRUN   = overrun_q;

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
- Sequences readout of the 8-channel ADC interface block: periodic sample ticks, snapshot of all CH0..CH7 words, block averaging over 2^AVG_LOG2 snapshots.
- Streams averaged results for the enabled channels to the indicator/display logic over a valid/ready handshake.
- Sits between the ADC interface outputs and downstream consumers, and sets the effective sample rate of the indicator path.

Parameters:
- SAMPLE_DIV, 50000: CLOCK cycles per sample tick (1 kHz at 50 MHz); must be >= 2.
- AVG_LOG2, 2: log2 of snapshots averaged per result set; range 0..4.
- WARMUP, 1000: cycles after reset release during which ticks are suppressed, so the ADC pipeline can fill.

Ports:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ENABLE  in  1  scan enable.
- CH_MASK  in  8  per-channel stream enable; bit i selects CHi.
- CH0..CH7  in  12 each  latest conversion words from the ADC interface.
- OUT_VALID  out  1  result beat valid.
- OUT_READY  in  1  consumer accepts the beat.
- OUT_CH  out  3  channel index of the beat.
- OUT_DATA  out  12  averaged value.
- OUT_LAST  out  1  last enabled channel of the set.
- BUSY  out  1  high while in STREAM.
- OVERRUN  out  1  sticky: a completed set was discarded.
- CLR_OVERRUN  in  1  clears OVERRUN.

Behaviour:
- Reset (RESET=0, asynchronous): all outputs 0; divider, warmup counter, accumulators, snap_count, result registers and state (ACCUM) all cleared.
- Warmup: counts WARMUP cycles after reset release; no ticks until done. Runs regardless of ENABLE.
- Divider:
  - Runs only when warmup is done and ENABLE=1.
  - Counts 0..SAMPLE_DIV-1 and wraps to 0.
  - Internal TICK is high for one cycle on the wrap, so the first tick comes SAMPLE_DIV cycles after enabling.
  - ENABLE=0 holds the divider at 0.
- Accumulate:
  - On each edge ending a TICK cycle: acc[i] += CHi for all 8 channels. acc width is 12+AVG_LOG2 (no overflow possible). snap_count increments.
  - When snap_count reaches 2^AVG_LOG2 on that same edge, res[i] = (acc[i]+CHi) >> AVG_LOG2 (truncating); acc and snap_count are cleared.
  - AVG_LOG2=0 passes samples straight through.
- Completed set, on the same edge:
  - Not in STREAM and CH_MASK != 0: capture CH_MASK into mask_q, load res, enter STREAM.
  - CH_MASK == 0: discard the set and stay in ACCUM; OVERRUN is not set.
  - Already in STREAM: discard the set, keep res unchanged, set OVERRUN.
- STREAM:
  - OUT_VALID=1 from the cycle after the completing TICK cycle (1-cycle latency).
  - ptr starts at the lowest set bit of mask_q. OUT_CH=ptr, OUT_DATA=res[ptr]. OUT_LAST=1 when mask_q has no set bit above ptr.
  - A beat transfers on OUT_VALID & OUT_READY; ptr then jumps to the next set bit, giving back-to-back beats with OUT_READY=1.
  - After the OUT_LAST transfer: OUT_VALID=0 next cycle and return to ACCUM.
  - While OUT_VALID=1 and OUT_READY=0, OUT_CH/OUT_DATA/OUT_LAST are held stable.
  - Accumulation keeps running during STREAM.
- BUSY equals (state == STREAM).
- ENABLE falling mid-operation:
  - acc and snap_count clear next edge and the divider stops.
  - A stream in progress runs to completion; OUT_VALID never drops before acceptance.
- OVERRUN: set/clear priority is set > CLR_OVERRUN > hold.
- CH_MASK changes during STREAM have no effect until the next set, since streaming uses mask_q.

Test Plan (sim params SAMPLE_DIV=4, AVG_LOG2=2, WARMUP=8):
- Full mask: CHi held at 100*i+1, CH_MASK=8'hFF, ENABLE=1, OUT_READY=1 -> first OUT_VALID 8+16+1 cycles after reset release; 8 consecutive beats with OUT_CH 0..7, OUT_DATA 1,101,...,701; OUT_LAST only on ch7; BUSY high exactly those 8 cycles.
- Sparse mask: CH_MASK=8'b1010_0100 -> beats ch2, ch5, ch7 only, OUT_LAST on ch7; no beats for other channels.
- Truncation: CH0 values 1, 2, 2, 2 on successive ticks -> OUT_DATA=1 for ch0 (sum 7 >> 2).
- Backpressure: OUT_READY=0 for 40 cycles after the first OUT_VALID -> OUT_VALID, OUT_CH=0 and OUT_DATA stay stable; OVERRUN rises on the edge ending the next completing TICK cycle; streamed data is the first set. CLR_OVERRUN pulse then clears OVERRUN. A CLR_OVERRUN coinciding with a new overrun leaves OVERRUN=1.
- Zero mask and ENABLE drop: CH_MASK=0 -> no OUT_VALID and OVERRUN stays 0. ENABLE dropped after 3 ticks then re-raised -> the next set averages 4 fresh ticks.
- Reset mid-stream: RESET=0 during beat 3 -> OUT_VALID, BUSY and OVERRUN go 0 asynchronously; after release, no OUT_VALID for at least WARMUP+4*SAMPLE_DIV cycles.
